// File: rtl/uart_tx_arbiter.sv
// Round-robin (per frame) arbiter merging two byte requesters onto one UART
// transmitter, with an inter-frame gap. Optional stall timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int GAP_TICKS     = 160,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CNT_MAX = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_TICKS);
`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last1_q, last1_d;   // 1: req1 was served last, so req0 wins the next tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;

    logic          sel_valid_s;
    logic [7:0]    sel_data_s;
    logic          sel_last_s;
    logic          beat_s;
    logic          frame_end_s;

    // Route the granted requester's signals
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = 8'h00;
        sel_last_s  = 1'b0;
        if (grant_q[0]) begin
            sel_valid_s = req0_valid;
            sel_data_s  = req0_data;
            sel_last_s  = req0_last;
        end else if (grant_q[1]) begin
            sel_valid_s = req1_valid;
            sel_data_s  = req1_data;
            sel_last_s  = req1_last;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    assign beat_s = (state_q == ST_XFER) && sel_valid_s && tx_ready;

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last1_d       = last1_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        frame_end_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && (!req1_valid || last1_q)) begin
                    grant_d = 2'b01;
                    state_d = ST_XFER;
                end else if (req1_valid) begin
                    grant_d = 2'b10;
                    state_d = ST_XFER;
                end else begin
                    grant_d = 2'b00;
                end
            end
            ST_XFER: begin
                frame_end_s = beat_s && sel_last_s;
`ifdef UART_ARB_TIMEOUT_EN
                if (beat_s) begin
                    cnt_d = CNT_ZERO;
                end else if (tick && !sel_valid_s) begin
                    if (cnt_q >= TO_LAST) begin
                        timeout_err_d = 1'b1;
                        frame_end_s   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
`endif
                if (frame_end_s) begin
                    last1_d = grant_q[1];
                    if (GAP_TICKS > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                cnt_d   = CNT_ZERO;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, pointer, counter and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q       <= 2'b00;
            last1_q       <= 1'b1;
            cnt_q         <= CNT_ZERO;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            last1_q       <= last1_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Byte path is transparent only while a frame is in flight
    always_comb begin
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == ST_XFER) begin
            tx_valid   = sel_valid_s;
            tx_data    = sel_data_s;
            req0_ready = grant_q[0] & tx_ready;
            req1_ready = grant_q[1] & tx_ready;
        end else begin
            tx_valid = 1'b0;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 160, the inter-frame gap length in oversample ticks (160 = one 10-bit character time at 16x).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 4096, the stall limit in oversample ticks; used only under UART_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick  input  1  one-cycle pulse at BAUD*OVERSAMPLE from the baud generator.
REQ-006 SHALL have ports req0_valid, req1_valid  input  1 each  requester byte valid.
REQ-007 SHALL have ports req0_data, req1_data  input  8 each  requester byte.
REQ-008 SHALL have ports req0_last, req1_last  input  1 each  marks the final byte of a frame.
REQ-009 SHALL have ports req0_ready, req1_ready  output  1 each  byte accepted when valid&ready.
REQ-010 SHALL have ports tx_valid output 1, tx_data output 8, tx_ready input 1  byte stream to the UART transmitter.
REQ-011 SHALL have port grant  output  2  one-hot owner (bit0 = req0, bit1 = req1, 00 = none).
REQ-012 SHALL have port busy  output  1  high in XFER or GAP.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on frame abort.

Function
REQ-014 SHALL implement states IDLE, XFER and GAP; reset state IDLE.
REQ-015 In IDLE with any reqN_valid high, SHALL register a grant and enter XFER on the next edge; one cycle of arbitration latency.
REQ-016 SHALL arbitrate round-robin by frame: when both are valid in IDLE, the requester not served last wins; after reset req0 wins the first tie.
REQ-017 In XFER, tx_valid, tx_data SHALL combinationally equal the granted reqN_valid, reqN_data, and reqN_ready SHALL equal tx_ready; the ungranted ready SHALL be 0.
REQ-018 Outside XFER, tx_valid, req0_ready and req1_ready SHALL be 0, and tx_data SHALL be 8'h00.
REQ-019 A beat SHALL be the cycle where tx_valid&tx_ready; a beat with the granted last high SHALL end the frame.
REQ-020 At frame end, if GAP_TICKS>0, SHALL enter GAP and load the gap counter with GAP_TICKS; otherwise SHALL return to IDLE.
REQ-021 In GAP, the counter SHALL decrement only on cycles with tick high; the state SHALL leave GAP for IDLE on the tick that brings the counter to 0.
REQ-022 The grant SHALL hold through GAP and clear to 00 on entry to IDLE; the last-served pointer SHALL update at frame end.
REQ-023 Requests arriving during XFER or GAP SHALL wait, with no loss and no preemption of the current frame.
REQ-024 A single-byte frame (valid and last together) SHALL be legal.
REQ-025 The counter width SHALL be clog2(max(GAP_TICKS,TIMEOUT_TICKS)+1); no wrap.

Reset
REQ-026 On reset: state IDLE, grant 00, busy 0, timeout_err 0, counters 0, pointer = req1-served, and all outputs at their REQ-018 values.
REQ-027 Reset asserted mid-frame SHALL abort the frame at once, without a gap.

Configuration
REQ-028 With UART_ARB_TIMEOUT_EN defined, SHALL count ticks in XFER while granted valid is low, and reset the count on any beat.
REQ-029 When that count reaches TIMEOUT_TICKS, SHALL pulse timeout_err for one cycle, drop the frame, and enter GAP; the pointer SHALL update as at frame end.
REQ-030 Without UART_ARB_TIMEOUT_EN, SHALL wait indefinitely for the granted requester, and timeout_err SHALL be tied 0.

Verification
REQ-031 Scenario 1: req0 sends 3-byte frame 0xA1,0xA2,0xA3 with tx_ready=1 -> grant=01 one cycle after valid; tx_data in order; GAP of 160 ticks; then IDLE with grant=00.
REQ-032 Scenario 2: req0 and req1 valid together, 2 frames each -> order req0, req1, req0, req1; no bytes interleaved within a frame.
REQ-033 Scenario 3: tx_ready toggles 1/0 during a req1 frame of 0x55,0xAA -> each byte sent exactly once; req1_ready equals tx_ready.
REQ-034 Scenario 4: GAP_TICKS=0 with back-to-back req1 frames -> IDLE directly after last, next grant 1 cycle later.
REQ-035 Scenario 5 (UART_ARB_TIMEOUT_EN, TIMEOUT_TICKS=8): req0 stalls after byte 1 -> timeout_err pulses after 8 ticks; a pending req1 is granted after the gap.
REQ-036 Scenario 6: reset asserted mid-frame -> outputs immediately at reset values; after release, a req1/req0 tie grants req0.
